// File: rtl/iram_write_seq.sv
// IRAM write sequencer: arbitrates CPU and spy writes into control memory and
// drives a registered setup/strobe/hold cycle with an optional parity bit.
module iram_write_seq #(
    parameter int WE_CYCLES = 2,
    parameter int PARITY_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        state_fetch,
    input  logic        cpu_iwrite,
    input  logic [13:0] cpu_addr,
    input  logic [48:0] iwr,
    input  logic [2:0]  spy_ld,
    input  logic [15:0] spy_data,
    input  logic        spy_go,
    input  logic [13:0] spy_addr,
    output logic [13:0] ram_addr,
    output logic [48:0] ram_wdata,
    output logic        ram_we,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done,
    output logic        spy_ack,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;
    typedef enum logic {OWN_CPU, OWN_SPY} owner_t;

    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

    state_t      state;
    owner_t      owner;
    logic [3:0]  we_cnt;
    logic        spy_pend;
    logic [13:0] pend_addr;
    logic [47:0] stage;

    logic        cpu_req;
    logic [47:0] load_data;
    logic        load_par;
    logic        iwr_unused;

    always_comb begin
        cpu_req    = state_fetch & cpu_iwrite;
        load_data  = (owner == OWN_CPU) ? iwr[47:0] : stage;
        load_par   = (PARITY_EN != 0) ? ~^load_data : 1'b0;
        iwr_unused = iwr[48];
        // The request term is combinational so the CPU stalls in the very cycle it asks.
        cpu_stall  = ((state != IDLE) && (owner == OWN_CPU)) ||
                     ((state == IDLE) && cpu_req && !reset);
        busy       = (state != IDLE) || spy_pend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            we_cnt    <= '0;
            spy_pend  <= 1'b0;
            pend_addr <= '0;
            stage     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            done      <= 1'b0;
            spy_ack   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done    <= 1'b0;
            spy_ack <= 1'b0;

            if (spy_ld[0]) stage[15:0]  <= spy_data;
            if (spy_ld[1]) stage[31:16] <= spy_data;
            if (spy_ld[2]) stage[47:32] <= spy_data;

            if (cpu_req && (state != IDLE)) overrun <= 1'b1;
            if (spy_go && spy_pend)         overrun <= 1'b1;
            if (spy_go) begin
                spy_pend  <= 1'b1;
                pend_addr <= spy_addr;
            end

            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        ram_addr <= cpu_addr;
                        owner    <= OWN_CPU;
                        state    <= LOAD;
                    end else if (spy_go || spy_pend) begin
                        // Direct acceptance overrides the pending-latch update above.
                        ram_addr <= spy_go ? spy_addr : pend_addr;
                        owner    <= OWN_SPY;
                        spy_pend <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    ram_wdata <= {load_par, load_data};
                    state     <= SETUP;
                end
                SETUP: begin
                    ram_we <= 1'b1;
                    we_cnt <= WE_LAST;
                    state  <= STROBE;
                end
                STROBE: begin
                    if (we_cnt == 4'd0) begin
                        ram_we  <= 1'b0;
                        done    <= 1'b1;
                        spy_ack <= (owner == OWN_SPY);
                        state   <= HOLD;
                    end else begin
                        we_cnt <= we_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iram_write_seq.sv
// Scoreboard bench for iram_write_seq: three parameter sets share one random
// stimulus stream; a timeline model predicts each write and per-cycle outputs.
module tb_iram_write_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        state_fetch;
    logic        cpu_iwrite;
    logic [13:0] cpu_addr;
    logic [48:0] iwr;
    logic [2:0]  spy_ld;
    logic [15:0] spy_data;
    logic        spy_go;
    logic [13:0] spy_addr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [13:0] addr;
        logic [48:0] data;
        logic        spy;
    } wr_t;

    always #5 clk = ~clk;

    task automatic check(input string name, input int cfg, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cfg%0d: got 0x%0h, expected 0x%0h at %0t", name, cfg, act, exp, $time);
        end
    endtask

    // Odd parity by counting ones: the bit makes the total count odd.
    function automatic logic ref_par(input logic [47:0] d, input int pe);
        int ones = 0;
        for (int i = 0; i < 48; i++) ones += int'(d[i]);
        return (pe != 0) && ((ones % 2) == 0);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int WC = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        localparam int PE = (g == 0) ? 1 : 0;

        logic [13:0] ram_addr;
        logic [48:0] ram_wdata;
        logic        ram_we, cpu_stall, busy, done, spy_ack, overrun;

        iram_write_seq #(.WE_CYCLES(WC), .PARITY_EN(PE)) dut (
            .clk(clk), .reset(reset), .state_fetch(state_fetch), .cpu_iwrite(cpu_iwrite),
            .cpu_addr(cpu_addr), .iwr(iwr), .spy_ld(spy_ld), .spy_data(spy_data),
            .spy_go(spy_go), .spy_addr(spy_addr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
            .ram_we(ram_we), .cpu_stall(cpu_stall), .busy(busy), .done(done),
            .spy_ack(spy_ack), .overrun(overrun)
        );

        wr_t         expq[$];
        int          left = 0;      // cycles of occupancy remaining; 0 = idle
        bit          own_cpu = 1'b1;
        logic [13:0] cur_addr = '0;
        bit          pend = 1'b0;
        logic [13:0] pend_a = '0;
        bit          ovr = 1'b0;
        logic [47:0] stage = '0;
        logic [47:0] d;
        bit          req;
        wr_t         e;
        wr_t         got;
        int          we_len = 0;

        always @(posedge clk) begin
            if (reset) begin
                left  = 0;
                pend  = 1'b0;
                ovr   = 1'b0;
                stage = '0;
                expq.delete();
            end else begin
                req = state_fetch && cpu_iwrite;
                if (spy_go && pend) ovr = 1'b1;
                if (left > 0) begin
                    if (req) ovr = 1'b1;
                    if (left == WC + 3) begin
                        d      = own_cpu ? iwr[47:0] : stage;
                        e.addr = cur_addr;
                        e.data = {ref_par(d, PE), d};
                        e.spy  = !own_cpu;
                        expq.push_back(e);
                    end
                    left--;
                    if (spy_go) begin pend = 1'b1; pend_a = spy_addr; end
                end else if (req) begin
                    left     = WC + 3;
                    own_cpu  = 1'b1;
                    cur_addr = cpu_addr;
                    if (spy_go) begin pend = 1'b1; pend_a = spy_addr; end
                end else if (spy_go || pend) begin
                    left     = WC + 3;
                    own_cpu  = 1'b0;
                    cur_addr = spy_go ? spy_addr : pend_a;
                    pend     = 1'b0;
                end
                if (spy_ld[0]) stage[15:0]  = spy_data;
                if (spy_ld[1]) stage[31:16] = spy_data;
                if (spy_ld[2]) stage[47:32] = spy_data;
            end
        end

        always @(negedge clk) begin
            check("ram_we", g, 64'(ram_we), 64'((left >= 2) && (left <= WC + 1)));
            check("done", g, 64'(done), 64'(left == 1));
            check("spy_ack", g, 64'(spy_ack), 64'((left == 1) && !own_cpu));
            check("cpu_stall", g, 64'(cpu_stall),
                  64'(((left > 0) && own_cpu) || ((left == 0) && state_fetch && cpu_iwrite && !reset)));
            check("busy", g, 64'(busy), 64'((left > 0) || pend));
            check("overrun", g, 64'(overrun), 64'(ovr));
            if (ram_we) begin
                we_len++;
                if (expq.size() > 0) begin
                    check("strobe_addr", g, 64'(ram_addr), 64'(expq[0].addr));
                    check("strobe_data", g, 64'(ram_wdata), 64'(expq[0].data));
                end
            end
            if (done) begin
                check("write_expected", g, 64'(expq.size() > 0), 64'(1));
                if (expq.size() > 0) begin
                    got = expq.pop_front();
                    check("wr_addr", g, 64'(ram_addr), 64'(got.addr));
                    check("wr_data", g, 64'(ram_wdata), 64'(got.data));
                    check("wr_ack", g, 64'(spy_ack), 64'(got.spy));
                    check("we_width", g, 64'(we_len), 64'(WC));
                end
                we_len = 0;
            end
            if (left == 0) we_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        state_fetch = 1'b0;
        cpu_iwrite  = 1'b0;
        spy_go      = 1'b0;
        spy_ld      = '0;
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [48:0] w);
        state_fetch = 1'b1;
        cpu_iwrite  = 1'b1;
        cpu_addr    = a;
        iwr         = w;
        tick();
        state_fetch = 1'b0;
        cpu_iwrite  = 1'b0;
    endtask

    task automatic spy_load(input logic [2:0] ld, input logic [15:0] v);
        spy_ld   = ld;
        spy_data = v;
        tick();
        spy_ld   = '0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_addr = '0;
        iwr = '0;
        spy_data = '0;
        spy_addr = '0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        cpu_write(14'h1234, 49'h0_8000_0000_0001);
        repeat (20) tick();

        spy_load(3'b001, 16'hBEEF);
        spy_load(3'b010, 16'hDEAD);
        spy_load(3'b100, 16'h0001);
        spy_go = 1'b1; spy_addr = 14'h0007;
        tick();
        spy_go = 1'b0;
        repeat (20) tick();

        spy_go = 1'b1; spy_addr = 14'h0155;
        cpu_write(14'h02AA, 49'h1_2345_6789_ABCD);
        spy_go = 1'b0;
        repeat (42) tick();

        cpu_write(14'h0321, 49'h0_0F0F_0F0F_0F0F);
        tick();
        cpu_write(14'h3FFF, 49'h1_FFFF_FFFF_FFFF);
        repeat (20) tick();

        cpu_write(14'h0ABC, 49'h0_1111_2222_3333);
        spy_go = 1'b1; spy_addr = 14'h0042;
        tick();
        spy_go = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        cpu_write(14'h0000, '0);
        repeat (20) tick();

        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            state_fetch = 1'($urandom);
            cpu_iwrite  = ($urandom_range(0, 11) == 0);
            cpu_addr    = 14'($urandom);
            iwr         = {17'($urandom), 32'($urandom)};
            spy_go      = ($urandom_range(0, 14) == 0);
            spy_addr    = 14'($urandom);
            spy_ld      = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            spy_data    = 16'($urandom);
            tick();
        end

        reset = 1'b0;
        idle_inputs();
        repeat (45) tick();
        check("queue_drained", 0, 64'(cfg[0].expq.size()), 64'(0));
        check("queue_drained", 1, 64'(cfg[1].expq.size()), 64'(0));
        check("queue_drained", 2, 64'(cfg[2].expq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
